// File: rtl/gray2bin_dec.sv
// Gray-to-binary decoder with a 2-entry output FIFO, gray-step checker,
// saturating error counter and sticky overflow flag.
module gray2bin_dec #(
  parameter int CODE_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [CODE_WIDTH-1:0]    gray_code,
  input  logic                     gray_code_valid,
  output logic [CODE_WIDTH-1:0]    bin_code,
  output logic                     bin_valid,
  input  logic                     bin_ready,
  output logic                     step_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     overflow,
  input  logic                     clr_err
);

  // Handshake: a word leaves the FIFO on any rising edge where bin_valid and
  // bin_ready are both high; the upstream side has no ready and is never stalled.

  function automatic logic [CODE_WIDTH-1:0] gray2bin(input logic [CODE_WIDTH-1:0] g);
    logic [CODE_WIDTH-1:0] b;
    b = '0;
    b[CODE_WIDTH-1] = g[CODE_WIDTH-1];
    for (int i = CODE_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [CODE_WIDTH-1:0]    mem_q [2];
  logic [CODE_WIDTH-1:0]    mem_d [2];
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [1:0]               count_q, count_d;
  logic [CODE_WIDTH-1:0]    bin_code_q, bin_code_d;
  logic                     bin_valid_q, bin_valid_d;
  logic                     step_err_q, step_err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     overflow_q, overflow_d;
  logic [CODE_WIDTH-1:0]    prev_gray_q, prev_gray_d;
  logic                     have_prev_q, have_prev_d;

  logic                     pop;
  logic                     push;
  logic                     drop;
  logic                     step_bad;

  always_comb begin
    pop      = bin_valid_q & bin_ready;
    push     = gray_code_valid & ((count_q != 2'd2) | pop);
    drop     = gray_code_valid & (count_q == 2'd2) & ~pop;
    step_bad = gray_code_valid & have_prev_q &
               ($countones(gray_code ^ prev_gray_q) != 1);

    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push) begin
      mem_d[wr_ptr_q] = gray2bin(gray_code);
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Head is re-registered so the outputs come straight from flops.
    bin_valid_d = (count_d != 2'd0);
    bin_code_d  = mem_d[rd_ptr_d];

    step_err_d = step_bad;
    err_cnt_d  = err_cnt_q;
    overflow_d = overflow_q;
    if (clr_err) begin
      err_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (step_bad && !(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end

    prev_gray_d = gray_code_valid ? gray_code : prev_gray_q;
    have_prev_d = have_prev_q | gray_code_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      bin_code_q  <= '0;
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      err_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      prev_gray_q <= '0;
      have_prev_q <= 1'b0;
    end else begin
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bin_code_q  <= bin_code_d;
      bin_valid_q <= bin_valid_d;
      step_err_q  <= step_err_d;
      err_cnt_q   <= err_cnt_d;
      overflow_q  <= overflow_d;
      prev_gray_q <= prev_gray_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign bin_code  = bin_code_q;
  assign bin_valid = bin_valid_q;
  assign step_err  = step_err_q;
  assign err_cnt   = err_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_gray2bin_dec.sv
// Bench for gray2bin_dec: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_gray2bin_dec;
  localparam int W  = 8;
  localparam int EW = 8;

  logic          clk;
  logic          rstn;
  logic [W-1:0]  gray_code;
  logic          gray_code_valid;
  logic [W-1:0]  bin_code;
  logic          bin_valid;
  logic          bin_ready;
  logic          step_err;
  logic [EW-1:0] err_cnt;
  logic          overflow;
  logic          clr_err;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  prev_m;
  bit            have_prev_m;
  logic [EW-1:0] cnt_m;
  bit            ovf_m;
  bit            serr_m;

  gray2bin_dec #(.CODE_WIDTH(W), .ERR_CNT_WIDTH(EW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .gray_code       (gray_code),
    .gray_code_valid (gray_code_valid),
    .bin_code        (bin_code),
    .bin_valid       (bin_valid),
    .bin_ready       (bin_ready),
    .step_err        (step_err),
    .err_cnt         (err_cnt),
    .overflow        (overflow),
    .clr_err         (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // binary value of a gray word: XOR of all right-shifts of it
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int bits_set(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic reset_model();
    exp_q.delete();
    prev_m      = '0;
    have_prev_m = 0;
    cnt_m       = '0;
    ovf_m       = 0;
    serr_m      = 0;
  endtask

  // one clock: model absorbs the inputs present at the edge; returns at negedge
  task automatic tick();
    bit pop, bad, drop;
    @(posedge clk);
    pop  = (exp_q.size() != 0) && bin_ready;
    bad  = gray_code_valid && have_prev_m && (bits_set(gray_code ^ prev_m) != 1);
    drop = gray_code_valid && (exp_q.size() == 2) && !pop;
    if (pop) void'(exp_q.pop_front());
    if (gray_code_valid && !drop) exp_q.push_back(g2b(gray_code));
    serr_m = bad;
    if (clr_err) begin
      cnt_m = '0;
      ovf_m = 0;
    end else begin
      if (bad && cnt_m != {EW{1'b1}}) cnt_m = cnt_m + 1'b1;
      if (drop) ovf_m = 1;
    end
    if (gray_code_valid) begin
      prev_m      = gray_code;
      have_prev_m = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    gray_code       = '0;
    gray_code_valid = 1'b0;
    clr_err         = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bin_ready = 1'b0;
    rstn      = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    n_vec++; if (bin_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bin_valid); end
    n_vec++; if (bin_code !== '0) begin n_err++; $display("FAIL reset_code: got %h want 00", bin_code); end
    n_vec++; if (step_err !== 1'b0) begin n_err++; $display("FAIL reset_step_err: got %b want 0", step_err); end
    n_vec++; if (err_cnt !== '0) begin n_err++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rstn = 1'b1;
  endtask

  task automatic test_basic_decode();
    logic [W-1:0] g_tab [5];
    logic [W-1:0] b_tab [5];
    g_tab = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06};
    b_tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    bin_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gray_code = g_tab[i]; gray_code_valid = 1'b1;
      tick();
      n_vec++; if (bin_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d]: got %b want 1", i, bin_valid); end
      n_vec++; if (bin_code !== b_tab[i]) begin n_err++; $display("FAIL basic_code[%0d]: got %h want %h", i, bin_code, b_tab[i]); end
      n_vec++; if (bin_code !== exp_q[0]) begin n_err++; $display("FAIL basic_model[%0d]: got %h want %h", i, bin_code, exp_q[0]); end
      n_vec++; if (step_err !== 1'b0) begin n_err++; $display("FAIL basic_step_err[%0d]: got %b want 0", i, step_err); end
    end
    idle_inputs();
    tick();
    n_vec++; if (bin_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", bin_valid); end
  endtask

  task automatic test_step_error();
    logic [W-1:0] g_tab [2];
    logic [W-1:0] b_tab [2];
    g_tab = '{8'h02, 8'h07};
    b_tab = '{8'h03, 8'h05};
    bin_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      gray_code = g_tab[i]; gray_code_valid = 1'b1;
      tick();
      n_vec++; if (bin_code !== b_tab[i]) begin n_err++; $display("FAIL step_code[%0d]: got %h want %h", i, bin_code, b_tab[i]); end
      n_vec++; if (step_err !== (i == 1)) begin n_err++; $display("FAIL step_pulse[%0d]: got %b want %b", i, step_err, (i == 1)); end
    end
    n_vec++; if (err_cnt !== 8'd1) begin n_err++; $display("FAIL step_err_cnt: got %0d want 1", err_cnt); end
    idle_inputs();
    tick();
    n_vec++; if (step_err !== 1'b0) begin n_err++; $display("FAIL step_pulse_end: got %b want 0", step_err); end
    n_vec++; if (err_cnt !== cnt_m) begin n_err++; $display("FAIL step_cnt_hold: got %0d want %0d", err_cnt, cnt_m); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] g_tab [3];
    logic [W-1:0] out_tab [2];
    g_tab   = '{8'h01, 8'h03, 8'h02};
    out_tab = '{8'h01, 8'h02};
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    bin_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      gray_code = g_tab[i]; gray_code_valid = 1'b1;
      tick();
    end
    idle_inputs();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_vec++; if (exp_q.size() != 2) begin n_err++; $display("FAIL ovf_model_depth: got %0d want 2", exp_q.size()); end
    n_vec++; if (bin_code !== 8'h01) begin n_err++; $display("FAIL ovf_head_hold: got %h want 01", bin_code); end
    bin_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (bin_valid !== 1'b1 || bin_code !== out_tab[i]) begin
        n_err++; $display("FAIL ovf_out[%0d]: got %b/%h want 1/%h", i, bin_valid, bin_code, out_tab[i]);
      end
      tick();
    end
    n_vec++; if (bin_valid !== 1'b0) begin n_err++; $display("FAIL ovf_dropped_word: got valid %b code %h want 0", bin_valid, bin_code); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [W-1:0] g_tab [3];
    logic [W-1:0] b_tab [3];
    g_tab = '{8'h06, 8'h07, 8'h05};
    b_tab = '{8'h04, 8'h05, 8'h06};
    bin_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gray_code = g_tab[i]; gray_code_valid = 1'b1;
      tick();
    end
    bin_ready = 1'b1;
    gray_code = g_tab[2]; gray_code_valid = 1'b1;
    tick();
    idle_inputs();
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pop_ovf: got %b want 0", overflow); end
    n_vec++; if (bin_code !== b_tab[1]) begin n_err++; $display("FAIL full_pop_head: got %h want %h", bin_code, b_tab[1]); end
    tick();
    n_vec++; if (bin_valid !== 1'b1 || bin_code !== b_tab[2]) begin
      n_err++; $display("FAIL full_pop_third: got %b/%h want 1/%h", bin_valid, bin_code, b_tab[2]);
    end
    tick();
    n_vec++; if (bin_valid !== 1'b0) begin n_err++; $display("FAIL full_pop_empty: got %b want 0", bin_valid); end
  endtask

  task automatic test_saturation();
    bin_ready = 1'b1;
    gray_code = 8'h05; gray_code_valid = 1'b1;
    for (int i = 0; i < 301; i++) tick();
    n_vec++; if (err_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_err_cnt: got %h want ff", err_cnt); end
    n_vec++; if (err_cnt !== cnt_m) begin n_err++; $display("FAIL sat_model: got %h want %h", err_cnt, cnt_m); end
    clr_err = 1'b1;
    tick();
    n_vec++; if (err_cnt !== 8'h00) begin n_err++; $display("FAIL sat_clear: got %h want 00", err_cnt); end
    n_vec++; if (step_err !== 1'b1) begin n_err++; $display("FAIL sat_clear_pulse: got %b want 1", step_err); end
    idle_inputs();
    tick();
    n_vec++; if (err_cnt !== 8'h00) begin n_err++; $display("FAIL sat_after_clear: got %h want 00", err_cnt); end
  endtask

  task automatic test_random();
    logic [W-1:0] g;
    g = prev_m;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 7) g = g ^ (W'(1) << $urandom_range(0, W - 1));
      else g = W'($urandom_range(0, (1 << W) - 1));
      gray_code       = g;
      gray_code_valid = ($urandom_range(0, 9) < 6);
      bin_ready       = ($urandom_range(0, 9) < 5);
      clr_err         = ($urandom_range(0, 19) == 0);
      tick();
      n_vec++; if (bin_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", i, bin_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        n_vec++; if (bin_code !== exp_q[0]) begin n_err++; $display("FAIL rand_code[%0d]: got %h want %h", i, bin_code, exp_q[0]); end
      end
      n_vec++; if (step_err !== serr_m) begin n_err++; $display("FAIL rand_step_err[%0d]: got %b want %b", i, step_err, serr_m); end
      n_vec++; if (err_cnt !== cnt_m) begin n_err++; $display("FAIL rand_err_cnt[%0d]: got %0d want %0d", i, err_cnt, cnt_m); end
      n_vec++; if (overflow !== ovf_m) begin n_err++; $display("FAIL rand_overflow[%0d]: got %b want %b", i, overflow, ovf_m); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bin_ready = 1'b0;
    gray_code = 8'h09; gray_code_valid = 1'b1; tick();
    gray_code = 8'h0B; tick();
    idle_inputs();
    n_vec++; if (bin_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", bin_valid); end
    #2 rstn = 1'b0;
    #1;
    n_vec++; if (bin_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b want 0", bin_valid); end
    n_vec++; if (bin_code !== '0 || err_cnt !== '0 || overflow !== 1'b0 || step_err !== 1'b0) begin
      n_err++; $display("FAIL mid_async_outs: got code %h cnt %h ovf %b serr %b want all 0", bin_code, err_cnt, overflow, step_err);
    end
    @(negedge clk);
    rstn = 1'b1;
    reset_model();
    bin_ready = 1'b1;
    gray_code = 8'h05; gray_code_valid = 1'b1;
    tick();
    idle_inputs();
    n_vec++; if (bin_valid !== 1'b1 || bin_code !== 8'h06) begin
      n_err++; $display("FAIL mid_first_word: got %b/%h want 1/06", bin_valid, bin_code);
    end
    n_vec++; if (step_err !== 1'b0) begin n_err++; $display("FAIL mid_first_unchecked: got %b want 0", step_err); end
    tick();
    n_vec++; if (bin_valid !== 1'b0) begin n_err++; $display("FAIL mid_discarded: got %b want 0", bin_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_decode();
    test_step_error();
    test_overflow();
    test_full_pop();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray2bin_dec.md
GRAY2BIN_DEC -- requirements
Module: gray2bin_dec

Interface
REQ-001 SHALL have parameter CODE_WIDTH, default 8, giving the gray/binary code width in bits (minimum 2).
REQ-002 SHALL have parameter ERR_CNT_WIDTH, default 8, giving the step-error counter width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 gray_code  input  CODE_WIDTH  gray code word from upstream encoder stage.
REQ-006 gray_code_valid  input  1  single-cycle qualifier for gray_code; there is no backpressure to upstream.
REQ-007 bin_code  output  CODE_WIDTH  decoded binary word at FIFO head.
REQ-008 bin_valid  output  1  bin_code valid; high while the FIFO is non-empty.
REQ-009 bin_ready  input  1  downstream accept; transfer occurs when bin_valid && bin_ready.
REQ-010 step_err  output  1  one-cycle pulse flagging an illegal gray step.
REQ-011 err_cnt  output  ERR_CNT_WIDTH  saturating count of step errors.
REQ-012 overflow  output  1  sticky flag; an input word was dropped.
REQ-013 clr_err  input  1  synchronous clear of err_cnt and overflow.

Function
REQ-014 SHALL decode on push: bin[MSB] = g[MSB]; bin[i] = bin[i+1] XOR g[i], for i from MSB-1 down to 0; stored words are binary.
REQ-015 SHALL buffer decoded words in a 2-entry FIFO, delivered in arrival order; bin_code/bin_valid SHALL come from registers only.
REQ-016 Latency: a word pushed into an empty FIFO at edge N SHALL appear with bin_valid=1 in the cycle following edge N, i.e. 1 cycle.
REQ-017 bin_code SHALL be held stable while bin_valid=1 and bin_ready=0.
REQ-018 Push SHALL be accepted when gray_code_valid=1 and either count<2, or count=2 with a pop in the same cycle.
REQ-019 Push with count=2 and no pop SHALL drop the word, set overflow, and leave FIFO contents and order unchanged.
REQ-020 Simultaneous push and pop at count=1 SHALL keep count=1, with the new word at the head the next cycle.
REQ-021 Pointers SHALL wrap modulo 2; count SHALL stay in the range 0..2.
REQ-022 SHALL keep prev_gray plus a have_prev flag; on every gray_code_valid (accepted or dropped), if have_prev=1 and popcount(gray_code XOR prev_gray) != 1, step_err SHALL pulse on the next cycle.
REQ-023 The first valid word after reset SHALL NOT be checked; it SHALL set have_prev.
REQ-024 Every valid word SHALL update prev_gray, including dropped words.
REQ-025 A repeated word (popcount 0) SHALL count as a step error.
REQ-026 err_cnt SHALL increment once per step_err and saturate at all-ones.
REQ-027 clr_err SHALL zero err_cnt and overflow at the next edge, and SHALL take priority over a same-cycle increment or overflow set.
REQ-028 clr_err SHALL NOT affect FIFO contents, prev_gray or have_prev.

Reset
REQ-029 On rstn low, the block SHALL immediately set: bin_valid=0, bin_code=0, step_err=0, err_cnt=0, overflow=0, count=0, pointers=0, have_prev=0, prev_gray=0.
REQ-030 Reset mid-operation SHALL discard buffered words.
REQ-031 The first valid word after reset release SHALL be treated per REQ-023.

Verification
REQ-032 Basic decode: with bin_ready=1, push gray 0x00, 0x01, 0x03, 0x02, 0x06 -> bin 0x00, 0x01, 0x02, 0x03, 0x04, each one cycle after input; step_err never asserts.
REQ-033 Step error: push gray 0x02 then 0x07 -> step_err pulses once, err_cnt=1; bin output 0x03 then 0x05.
REQ-034 Overflow: with bin_ready=0, push 0x01, 0x03, 0x02 -> overflow=1, count=2; raising bin_ready yields 0x01 then 0x02, and 0x03 (from 0x02) is never output.
REQ-035 Full with simultaneous pop: count=2, bin_ready=1 and push in the same cycle -> push accepted, overflow stays 0, all three words output in order.
REQ-036 Saturation and clear: force 300 illegal steps with ERR_CNT_WIDTH=8 -> err_cnt=0xFF; then clr_err pulsed in the same cycle as an error -> err_cnt=0.
REQ-037 Reset mid-operation: rstn low with 2 words buffered -> bin_valid=0 immediately; after release, the first push of gray 0x05 -> bin 0x06 with no step_err.
